// File: rtl/mux2x1_sel_arb_pkg.sv
// Shared definitions for the 2:1 mux select arbiter: state encoding, defaults
// and the round-robin pick used both from IDLE and at burst handover.
package mux2x1_sel_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } state_e;

  localparam int BURST_LEN_DEF = 4;
  localparam int CNT_W_DEF     = 8;

  // Grant the preferred channel when both request, otherwise whoever requests.
  function automatic state_e arb_pick(input logic prefer, input logic r0, input logic r1);
    if (r0 && r1)
      return prefer ? ST_G1 : ST_G0;
    else if (r0)
      return ST_G0;
    else if (r1)
      return ST_G1;
    else
      return ST_IDLE;
  endfunction

endpackage

// File: rtl/mux2x1_sel_arb_rr_burst_cnt.sv
// Burst length counter: counts cycles spent in a grant state and flags the
// final permitted cycle of the burst.
module rr_burst_cnt #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr)
      r_cnt <= '0;
    else if (en)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign last = (r_cnt == CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/mux2x1_sel_arb.sv
// Round-robin burst arbiter driving the select of a downstream 2:1 mux.
// All outputs come straight from flops; no combinational path from req*.
module mux2x1_sel_arb
  import mux2x1_sel_arb_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic select,
  output logic busy
);

  state_e r_state;
  state_e w_next;
  logic   r_ptr;
  logic   r_gnt0;
  logic   r_gnt1;
  logic   r_sel;
  logic   r_busy;
  logic   w_end;
  logic   w_in_grant;
  logic   w_cnt_clr;
  logic   w_last;

  rr_burst_cnt #(
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_cnt_clr),
    .en    (w_in_grant),
    .last  (w_last)
  );

  // A burst ends on owner release or expiry; handover prefers the other channel.
  always_comb begin
    w_next = r_state;
    w_end  = 1'b0;
    case (r_state)
      ST_IDLE: w_next = arb_pick(r_ptr, req0, req1);
      ST_G0: begin
        if (!req0 || w_last) begin
          w_end  = 1'b1;
          w_next = arb_pick(1'b1, req0, req1);
        end
      end
      ST_G1: begin
        if (!req1 || w_last) begin
          w_end  = 1'b1;
          w_next = arb_pick(1'b0, req0, req1);
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_in_grant = (r_state == ST_G0) || (r_state == ST_G1);
  assign w_cnt_clr  = w_end || !w_in_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_busy  <= 1'b0;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_end)
        r_ptr <= (r_state == ST_G0);
      r_gnt0 <= (w_next == ST_G0);
      r_gnt1 <= (w_next == ST_G1);
      r_busy <= (w_next == ST_G0) || (w_next == ST_G1);
      // select only moves on grant entry, so IDLE keeps the last owner
      if (w_next == ST_G0)
        r_sel <= 1'b0;
      else if (w_next == ST_G1)
        r_sel <= 1'b1;
    end
  end

  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign busy   = r_busy;
  assign select = r_sel;

endmodule

// File: tb/tb_mux2x1_sel_arb.sv
// Bench for mux2x1_sel_arb: two instances (BURST_LEN 4 and 1) on shared
// inputs, a per-cycle reference model, and directed literal expectations.
module tb_mux2x1_sel_arb;

  localparam int BLA = 4;
  localparam int BLB = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b1;
  logic req1 = 1'b1;
  logic a_gnt0, a_gnt1, a_sel, a_busy;
  logic b_gnt0, b_gnt1, b_sel, b_busy;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux2x1_sel_arb #(.BURST_LEN(BLA), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .select(a_sel), .busy(a_busy)
  );

  mux2x1_sel_arb #(.BURST_LEN(BLB), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .select(b_sel), .busy(b_busy)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner (-1 = none), cycles already used in the burst,
  // preferred channel and last granted channel, per instance.
  int m_owner[2];
  int m_used[2];
  bit m_ptr[2];
  bit m_sel[2];
  bit m_live = 1'b0;

  function automatic bit rq(input int c);
    return (c == 0) ? req0 : req1;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int bl;
      bl = (i == 0) ? BLA : BLB;
      if (!rst_n) begin
        m_owner[i] = -1;
        m_used[i]  = 0;
        m_ptr[i]   = 1'b0;
        m_sel[i]   = 1'b0;
      end else if (m_owner[i] >= 0 && rq(m_owner[i]) && m_used[i] + 1 < bl) begin
        m_used[i] = m_used[i] + 1;
      end else begin
        if (m_owner[i] >= 0)
          m_ptr[i] = (m_owner[i] == 0);
        m_used[i] = 0;
        if (rq(int'(m_ptr[i])))
          m_owner[i] = int'(m_ptr[i]);
        else if (rq(int'(!m_ptr[i])))
          m_owner[i] = int'(!m_ptr[i]);
        else
          m_owner[i] = -1;
        if (m_owner[i] >= 0)
          m_sel[i] = (m_owner[i] == 1);
      end
    end
    m_live = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("A.gnt0 model",   {15'd0, a_gnt0}, {15'd0, m_owner[0] == 0});
      chk("A.gnt1 model",   {15'd0, a_gnt1}, {15'd0, m_owner[0] == 1});
      chk("A.busy model",   {15'd0, a_busy}, {15'd0, m_owner[0] >= 0});
      chk("A.select model", {15'd0, a_sel},  {15'd0, m_sel[0]});
      chk("B.gnt0 model",   {15'd0, b_gnt0}, {15'd0, m_owner[1] == 0});
      chk("B.gnt1 model",   {15'd0, b_gnt1}, {15'd0, m_owner[1] == 1});
      chk("B.busy model",   {15'd0, b_busy}, {15'd0, m_owner[1] >= 0});
      chk("B.select model", {15'd0, b_sel},  {15'd0, m_sel[1]});
      chk("A onehot", {15'd0, a_gnt0 & a_gnt1}, 16'd0);
      chk("B onehot", {15'd0, b_gnt0 & b_gnt1}, 16'd0);
      chk("A busy==or", {15'd0, a_busy}, {15'd0, a_gnt0 | a_gnt1});
      chk("B busy==or", {15'd0, b_busy}, {15'd0, b_gnt0 | b_gnt1});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] seq_a;
  logic [15:0] seq_b;

  initial begin
    seq_a = '0;
    seq_b = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst A.outs", {12'd0, a_gnt0, a_gnt1, a_busy, a_sel}, 16'd0);
      chk("rst B.outs", {12'd0, b_gnt0, b_gnt1, b_busy, b_sel}, 16'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) begin
        chk("release A.gnt0", {15'd0, a_gnt0}, 16'd1);
        chk("release B.gnt0", {15'd0, b_gnt0}, 16'd1);
      end
      seq_a = {seq_a[14:0], a_gnt1};
      seq_b = {seq_b[14:0], b_sel};
    end
    chk("contention A gnt1 seq", seq_a, 16'b0000111100001111);
    chk("burst1 B select seq", seq_b, 16'b0101010101010101);

    tick();
    tick();
    chk("A in G0 before release", {15'd0, a_gnt0}, 16'd1);
    req0 = 1'b0;
    tick();
    chk("early rel A.gnt1", {15'd0, a_gnt1}, 16'd1);
    chk("early rel A.gnt0", {15'd0, a_gnt0}, 16'd0);
    req1 = 1'b0;
    tick();
    chk("idle A.busy", {15'd0, a_busy}, 16'd0);
    chk("idle A.select holds", {15'd0, a_sel}, 16'd1);
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    chk("ptr back A.gnt0", {15'd0, a_gnt0}, 16'd1);
    chk("ptr back A.select", {15'd0, a_sel}, 16'd0);

    req0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("single A.gnt1", {15'd0, a_gnt1}, 16'd1);
      chk("single A.select", {15'd0, a_sel}, 16'd1);
    end

    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst A.outs", {12'd0, a_gnt0, a_gnt1, a_busy, a_sel}, 16'd0);
    rst_n = 1'b1;
    req0 = 1'b1;
    tick();
    chk("restart A.gnt0", {15'd0, a_gnt0}, 16'd1);
    chk("restart B.gnt0", {15'd0, b_gnt0}, 16'd1);

    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    chk("final A.busy", {15'd0, a_busy}, 16'd0);
    chk("final A.select", {15'd0, a_sel}, 16'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
